// File: rtl/iomem_pkg.sv
// iomem_pkg: shared iomem bus constants, address map and DMA state encoding
package iomem_pkg;
  typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP} dma_state_t;
  localparam logic [3:0] WSTRB_RD = 4'b0000;
  localparam logic [3:0] WSTRB_WR = 4'b1111;
  localparam logic [31:0] GPIO_ADDR = 32'h0300_0000;
  localparam logic [31:0] RNG_ADDR = 32'h0300_1000;
  localparam logic [31:0] URAM_BASE = 32'h0300_2000;
  localparam int URAM_WORDS = 256;
endpackage

// File: rtl/iomem_watchdog.sv
// iomem_watchdog: counts stalled bus cycles and flags when the limit is reached
module iomem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [15:0] cnt;
  always_ff @(posedge clk)
    if (reset || clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 16'd1;
  assign expired = cnt == 16'(TIMEOUT);
endmodule

// File: rtl/iomem_dma.sv
// iomem_dma: read-then-write word copy initiator on the iomem valid/ready bus
module iomem_dma import iomem_pkg::*; #(
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] count,
  input  logic             src_fixed,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_done,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);
  dma_state_t state, state_nx;
  logic [31:0] src, dst, data;
  logic [CNT_W-1:0] cnt;
  logic fixed, expired, accept, abort, last;
  iomem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .reset(reset),
    .clear(!mem_valid),
    .enable(mem_valid && !mem_ready),
    .expired(expired)
  );
  always_comb begin
    mem_valid = state == RD || state == WR;
    mem_wstrb = state == WR ? WSTRB_WR : WSTRB_RD;
    mem_addr = state == WR ? dst : state == RD ? src : '0;
    mem_wdata = data;
    // a start in the done cycle would collide with the job still closing out
    accept = state == IDLE && start && !done;
    abort = mem_valid && !mem_ready && expired;
    last = words_done + CNT_W'(1) == cnt;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept && count != '0 ? RD : IDLE;
      RD: state_nx = mem_ready ? RD_GAP : abort ? IDLE : RD;
      RD_GAP: state_nx = WR;
      WR: state_nx = mem_ready ? WR_GAP : abort ? IDLE : WR;
      WR_GAP: state_nx = words_done == cnt ? IDLE : RD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (reset) begin
      src <= '0;
      dst <= '0;
      data <= '0;
      cnt <= '0;
      fixed <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      words_done <= '0;
    end else begin
      done <= (accept && count == '0) || abort || (state == WR && mem_ready && last);
      busy <= (busy && !done) || (accept && count != '0);
      if (accept) begin
        src <= {src_addr[31:2], 2'b00};
        dst <= {dst_addr[31:2], 2'b00};
        cnt <= count;
        fixed <= src_fixed;
        error <= 1'b0;
        words_done <= '0;
      end
      if (state == RD && mem_ready) data <= mem_rdata;
      if (state == WR && mem_ready) begin
        words_done <= words_done + CNT_W'(1);
        dst <= dst + 32'd4;
        if (!fixed) src <= src + 32'd4;
      end
      if (abort) error <= 1'b1;
    end
endmodule
